// File: rtl/xbus_master.sv
// CPU-side xbus initiator: one load/store per transaction, one-hot slot select,
// byte-lane steering on writes and aligned, extended read data on loads.
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif
`ifndef XADDRW
`define XADDRW 16
`endif

// state | meaning
// IDLE  | waiting for cpu_req; latches the request and checks for faults
// ISSUE | chip select, strobes, address and write data on the bus
// WAIT  | read chip select held while the wait counter runs down
// RESP  | one-cycle cpu_ready (and cpu_error on a fault); bus idle
module xbus_master #(
  parameter int          N_SLV   = 4,
  parameter logic [31:0] IO_BASE = 32'h0000_F000,
  parameter int          RD_WAIT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [1:0]                cpu_size,
  input  logic                      cpu_unsigned,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_error,
  output logic [N_SLV-1:0]          xbus_cs,
  output logic                      xbus_we,
  output logic [`XBYTEC-1:0]        xbus_be,
  output logic [`XADDRW-1:0]        xbus_addr,
  output logic [`XDATAW-1:0]        xbus_wdata,
  input  logic [N_SLV*`XDATAW-1:0]  xbus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  ofs_q;
  logic [3:0]  idx_q;
  logic        fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] slot_word;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] ofs,
                                          input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {ofs, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    fault = 1'b0;
    if (cpu_size == 2'b11) fault = 1'b1;
    if (cpu_size == 2'b01 && cpu_addr[0]) fault = 1'b1;
    if (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00) fault = 1'b1;
    if (cpu_addr[31:12] != IO_BASE[31:12]) fault = 1'b1;
    if (32'(cpu_addr[11:8]) >= N_SLV) fault = 1'b1;
  end

  always_comb begin
    be_next    = 4'b0000;
    wdata_next = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        be_next    = 4'b0001 << cpu_addr[1:0];
        wdata_next = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << cpu_addr[1:0];
        wdata_next = {2{cpu_wdata[15:0]}};
      end
      default: be_next = 4'b1111;
    endcase
    if (!cpu_we) be_next = 4'b0000;
  end

  // Out-of-range slots never reach ISSUE, so unmatched indices can read as zero.
  always_comb begin
    slot_word = '0;
    for (int i = 0; i < N_SLV; i++)
      if (idx_q == 4'(i)) slot_word = xbus_rdata[i*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      ofs_q      <= 2'b00;
      idx_q      <= 4'h0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_error  <= 1'b0;
      xbus_cs    <= '0;
      xbus_we    <= 1'b0;
      xbus_be    <= '0;
      xbus_addr  <= '0;
      xbus_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q   <= cpu_we;
            uns_q  <= cpu_unsigned;
            size_q <= cpu_size;
            ofs_q  <= cpu_addr[1:0];
            idx_q  <= cpu_addr[11:8];
            if (fault) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_error <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              state      <= ISSUE;
              xbus_cs    <= N_SLV'(1) << cpu_addr[11:8];
              xbus_we    <= cpu_we;
              xbus_be    <= be_next;
              xbus_addr  <= cpu_addr[`XADDRW-1:0];
              xbus_wdata <= wdata_next;
            end
          end
        end
        ISSUE: begin
          if (!we_q && RD_WAIT > 0) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end else begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_rdata <= we_q ? 32'h0 : extract(slot_word, ofs_q, size_q, uns_q);
            xbus_cs   <= '0;
            xbus_we   <= 1'b0;
            xbus_be   <= '0;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_rdata <= extract(slot_word, ofs_q, size_q, uns_q);
            xbus_cs   <= '0;
            xbus_we   <= 1'b0;
            xbus_be   <= '0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_master.sv
// Directed bench for xbus_master: sw/LED responder in slot 0, constant slots
// elsewhere; one zero-wait instance and one with two read wait cycles.
module tb_xbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req2;
  logic        cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [7:0]  sw, led;
  logic [127:0] rdata_bus;

  logic [31:0] rdata0, rdata2;
  logic        ready0, ready2, error0, error2, we0, we2;
  logic [3:0]  cs0, cs2, be0, be2;
  logic [15:0] addr0, addr2;
  logic [31:0] wdata0, wdata2;

  int checks = 0;
  int errors = 0;
  int n_ready;

  logic [1:0]  f_size [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
  logic [31:0] f_addr [5] = '{32'h0000_F001, 32'h0000_F000, 32'h0000_F002,
                              32'h0000_F500, 32'h0000_0000};

  always #5 clk = ~clk;

  assign rdata_bus = {32'hDEAD_BEEF, 32'h8001_7FFE, 32'h1111_2222, {8'h00, sw, 8'h00, led}};

  // Slot 0 LED register only listens to byte lane 0.
  always @(posedge clk)
    if (rst) led <= 8'h00;
    else if (cs0[0] && we0 && be0[0]) led <= wdata0[7:0];

  xbus_master #(.N_SLV(4), .IO_BASE(32'h0000_F000), .RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .cpu_req(req0), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata0), .cpu_ready(ready0), .cpu_error(error0), .xbus_cs(cs0),
    .xbus_we(we0), .xbus_be(be0), .xbus_addr(addr0), .xbus_wdata(wdata0),
    .xbus_rdata(rdata_bus)
  );

  xbus_master #(.N_SLV(4), .IO_BASE(32'h0000_F000), .RD_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .cpu_req(req2), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(rdata2), .cpu_ready(ready2), .cpu_error(error2), .xbus_cs(cs2),
    .xbus_we(we2), .xbus_be(be2), .xbus_addr(addr2), .xbus_wdata(wdata2),
    .xbus_rdata(rdata_bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single IDLE edge; returns #1 after that edge.
  task automatic issue(input logic to2, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_we = we; cpu_size = size; cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wdata;
    if (to2) req2 = 1'b1;
    else     req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req2 = 1'b0;
    cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; sw = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs0, 4'h0);
    check("rst_ready", ready0, 1'b0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_be_we", {be0, we0, addr0, wdata0}, 53'h0);
    check("rst_cs2", cs2, 4'h0);
    rst = 1'b0;
    step();

    // store byte A5 to F002: lane 2 only, LED untouched
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_F002, 32'h0000_00A5);
    check("sb2_cs", cs0, 4'b0001);
    check("sb2_we", we0, 1'b1);
    check("sb2_be", be0, 4'b0100);
    check("sb2_wdata", wdata0, 32'hA5A5_A5A5);
    check("sb2_addr", addr0, 16'hF002);
    check("sb2_ready_early", ready0, 1'b0);
    step();
    check("sb2_ready", {ready0, error0}, 2'b10);
    check("sb2_cs_off", cs0, 4'h0);
    check("sb2_rdata", rdata0, 32'h0);
    check("sb2_led", led, 8'h00);
    step();

    // store byte 5A to F000 updates the LED
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_F000, 32'h1234_565A);
    check("sb0_be", be0, 4'b0001);
    check("sb0_wdata", wdata0, 32'h5A5A_5A5A);
    step();
    check("sb0_ready", ready0, 1'b1);
    check("sb0_led", led, 8'h5A);
    step();

    // store half BEEF to slot 1 upper half
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_F102, 32'h0000_BEEF);
    check("sh_cs", cs0, 4'b0010);
    check("sh_be", be0, 4'b1100);
    check("sh_wdata", wdata0, 32'hBEEF_BEEF);
    step();
    check("sh_ready", ready0, 1'b1);
    step();

    // loads from slot 0 (sw=80, led=5A)
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_F000, 32'h0);
    check("lw_cs", cs0, 4'b0001);
    check("lw_we_be", {we0, be0}, 5'b0);
    step();
    check("lw_ready", ready0, 1'b1);
    check("lw_rdata", rdata0, 32'h0080_005A);
    step();
    check("lw_hold", {ready0, rdata0}, {1'b0, 32'h0080_005A});

    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_F002, 32'h0);
    step();
    check("lb_signed", rdata0, 32'hFFFF_FF80);
    step();
    issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_F002, 32'h0);
    step();
    check("lb_unsigned", rdata0, 32'h0000_0080);
    step();
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_F202, 32'h0);
    check("lh_cs", cs0, 4'b0100);
    step();
    check("lh_signed", rdata0, 32'hFFFF_8001);
    step();
    issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_F202, 32'h0);
    step();
    check("lh_unsigned", rdata0, 32'h0000_8001);
    step();
    issue(1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_F200, 32'h0);
    step();
    check("lh_pos", rdata0, 32'h0000_7FFE);
    step();

    // faults: misaligned half, size 11, misaligned word, slot 5, outside I/O
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b0, f_size[i], 1'b0, f_addr[i], 32'h0);
      check($sformatf("flt%0d_resp", i), {ready0, error0}, 2'b11);
      check($sformatf("flt%0d_cs", i), cs0, 4'h0);
      check($sformatf("flt%0d_rdata", i), rdata0, 32'h0);
      step();
      check($sformatf("flt%0d_after", i), {ready0, error0, cs0}, 6'h0);
      step();
    end

    // two wait cycles: chip select for 3 cycles, late sw value returned
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_F000, 32'h0);
    check("rw_cs1", cs2, 4'b0001);
    sw = 8'h11;
    step();
    check("rw_cs2", {cs2, ready2}, {4'b0001, 1'b0});
    step();
    check("rw_cs3", {cs2, ready2}, {4'b0001, 1'b0});
    sw = 8'h33;
    step();
    check("rw_ready", {ready2, error2, cs2}, {1'b1, 1'b0, 4'h0});
    check("rw_rdata", rdata2, 32'h0033_005A);
    step();
    check("rw_done", ready2, 1'b0);
    sw = 8'h80;

    // reset in ISSUE aborts the store
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_F000, 32'h0000_00FF);
    check("ra_cs", cs0, 4'b0001);
    rst = 1'b1;
    step();
    check("ra_cs_off", cs0, 4'h0);
    check("ra_ready", ready0, 1'b0);
    check("ra_outs", {we0, be0, addr0, wdata0, rdata0, error0}, 86'h0);
    check("ra_rdata2", rdata2, 32'h0);
    rst = 1'b0;
    step();
    check("ra_no_ready", ready0, 1'b0);
    check("ra_led", led, 8'h00);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_F000, 32'h0);
    step();
    check("ra_new", {ready0, rdata0}, {1'b1, 32'h0080_0000});
    step();

    // cpu_req held high: one transaction every 3 cycles
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_unsigned = 1'b0; cpu_addr = 32'h0000_F100;
    req0 = 1'b1;
    n_ready = 0;
    repeat (9) begin
      step();
      if (ready0) n_ready++;
    end
    req0 = 1'b0;
    check("b2b_count", n_ready, 3);
    check("b2b_rdata", rdata0, 32'h1111_2222);
    step();
    step();
    check("b2b_idle", {ready0, cs0}, 5'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
